// File: rtl/echo_checker_pkg.sv
// echo_checker_pkg: shared definitions for the echo checker.
//   DATA_BITS  - payload bits per UART frame
//   FRAME_BITS - start + data + stop bits
//   state_t    - checker FSM states
//   rx_state_t - receiver states
//   sat_inc    - 8-bit saturating increment used by the error counter
package echo_checker_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_HOLD
  } rx_state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/echo_checker_rx.sv
// echo_checker_rx: UART receiver (8N1) for the echo checker.
// Parameters:
//   BAUDRATE   - bit period in clk cycles
// Ports:
//   clk        - system clock, rising edge
//   rstn       - asynchronous active-low reset
//   rx         - asynchronous serial input
//   byte_valid - one-cycle pulse when a frame completes
//   data       - received byte, valid with byte_valid
//   frame_err  - stop bit was sampled low, valid with byte_valid
module echo_checker_rx
  import echo_checker_pkg::*;
#(
  parameter int unsigned BAUDRATE = 104
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] data,
  output logic       frame_err
);

  localparam int unsigned   CW      = $clog2(BAUDRATE) + 1;
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUDRATE - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUDRATE / 2 - 1);

  // sync[1] is the synchronised line, sync[2] its previous value. Resetting
  // them low means a falling edge needs the line to be seen high first.
  logic [2:0]    sync;
  logic          rx_s;
  logic          fall;
  rx_state_t     st;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    sh;
  logic          stop_bit;

  assign rx_s = sync[1];
  assign fall = sync[2] & ~sync[1];

  // The byte is released one bit period after the stop-bit sample so that a
  // looped-back echo completes after the transmitter has left its stop bit.
  // A new falling edge during that hold releases the byte early.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync       <= '0;
      st         <= RX_IDLE;
      cnt        <= '0;
      bitn       <= '0;
      sh         <= '0;
      stop_bit   <= 1'b0;
      byte_valid <= 1'b0;
      data       <= '0;
      frame_err  <= 1'b0;
    end else begin
      sync       <= {sync[1:0], rx};
      byte_valid <= 1'b0;
      case (st)
        RX_IDLE: begin
          if (fall) begin
            st  <= RX_START;
            cnt <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF_M1) begin
            cnt  <= '0;
            bitn <= '0;
            st   <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_M1) begin
            cnt  <= '0;
            sh   <= {rx_s, sh[7:1]};
            bitn <= bitn + 1'b1;
            if (bitn == 3'(DATA_BITS - 1)) st <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL_M1) begin
            cnt      <= '0;
            stop_bit <= rx_s;
            st       <= RX_HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_HOLD: begin
          if (fall || cnt == FULL_M1) begin
            byte_valid <= 1'b1;
            data       <= sh;
            frame_err  <= ~stop_bit;
            cnt        <= '0;
            st         <= fall ? RX_START : RX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/echo_checker.sv
// echo_checker: sends bytes 0..N-1 over a UART line and checks the echo.
// Parameters:
//   BAUDRATE - bit period in clk cycles (default B115200: 104 at 12 MHz)
//   TIMEOUT  - bit periods to wait for each echoed byte
// Ports:
//   clk, rstn - clock (rising edge), asynchronous active-low reset
//   start     - one-cycle run request, ignored while busy
//   count     - bytes per run, 0 means 256
//   tx / rx   - serial line to / from the device under test
//   busy      - run in progress
//   done      - one-cycle end-of-run pulse
//   pass      - last run had zero errors
//   errors    - saturating error count of current/last run
//   last_rx   - last byte received while waiting for an echo
//   inject    - only with ECHO_CHECKER_INJECT_EN: invert bit 0 of the byte
//               being loaded for transmission
`ifndef B115200
`define B115200 104
`endif

module echo_checker
  import echo_checker_pkg::*;
#(
  parameter int unsigned BAUDRATE = `B115200,
  parameter int unsigned TIMEOUT  = 30
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] count,
  output logic       tx,
  input  logic       rx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] errors,
  output logic [7:0] last_rx
`ifdef ECHO_CHECKER_INJECT_EN
  ,
  input  logic       inject
`endif
);

  localparam int unsigned   CW      = $clog2(BAUDRATE) + 1;
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUDRATE - 1);
  localparam int unsigned   TLIM    = TIMEOUT * BAUDRATE;
  localparam int unsigned   TW      = $clog2(TLIM) + 1;
  localparam logic [TW-1:0] TLIM_M1 = TW'(TLIM - 1);

  state_t        state;
  logic [8:0]    n;
  logic [8:0]    k;
  logic [CW-1:0] bcnt;
  logic [3:0]    bitn;
  logic [8:0]    sr;
  logic [TW-1:0] tcnt;
  logic [7:0]    rx_byte;
  logic          rx_ferr;

  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_frame_err;

  logic [8:0]    k_next;
  logic          more;
  logic          timeout;
  logic          bad;
  logic          advance;
  logic [7:0]    err_nxt;
  logic [7:0]    load_val;

  echo_checker_rx #(
    .BAUDRATE(BAUDRATE)
  ) u_rx (
    .clk       (clk),
    .rstn      (rstn),
    .rx        (rx),
    .byte_valid(rx_valid),
    .data      (rx_data),
    .frame_err (rx_frame_err)
  );

  always_comb begin
    k_next   = k + 9'd1;
    more     = (k_next < n);
    timeout  = (state == ST_WAIT) && !rx_valid && (tcnt == TLIM_M1);
    bad      = (state == ST_CHECK) && ((rx_byte != k[7:0]) || rx_ferr);
    advance  = timeout || (state == ST_CHECK);
    err_nxt  = (timeout || bad) ? sat_inc(errors) : errors;
    load_val = (state == ST_IDLE) ? 8'h00 : k_next[7:0];
`ifdef ECHO_CHECKER_INJECT_EN
    load_val[0] = load_val[0] ^ inject;
`endif
  end

  // Loading a byte drives the start bit directly and parks {stop, data} in
  // sr, which shifts in ones so tx rests high after the stop bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      errors  <= '0;
      last_rx <= '0;
      n       <= '0;
      k       <= '0;
      bcnt    <= '0;
      bitn    <= '0;
      sr      <= '1;
      tcnt    <= '0;
      rx_byte <= '0;
      rx_ferr <= 1'b0;
    end else begin
      done   <= 1'b0;
      errors <= err_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            n      <= (count == 8'd0) ? 9'd256 : {1'b0, count};
            k      <= '0;
            errors <= '0;
            busy   <= 1'b1;
            tx     <= 1'b0;
            sr     <= {1'b1, load_val};
            bcnt   <= '0;
            bitn   <= '0;
            state  <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (bcnt == FULL_M1) begin
            bcnt <= '0;
            if (bitn == 4'(FRAME_BITS - 1)) begin
              tcnt  <= '0;
              state <= ST_WAIT;
            end else begin
              tx   <= sr[0];
              sr   <= {1'b1, sr[8:1]};
              bitn <= bitn + 1'b1;
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (rx_valid) begin
            rx_byte <= rx_data;
            rx_ferr <= rx_frame_err;
            last_rx <= rx_data;
            state   <= ST_CHECK;
          end else if (!timeout) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_CHECK: ;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase

      // Shared exit of WAIT (timeout) and CHECK: next byte or finish.
      if (advance) begin
        if (more) begin
          k     <= k_next;
          tx    <= 1'b0;
          sr    <= {1'b1, load_val};
          bcnt  <= '0;
          bitn  <= '0;
          state <= ST_SEND;
        end else begin
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (err_nxt == 8'd0);
          state <= ST_DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_echo_checker.sv
// tb_echo_checker: bench for echo_checker. A line monitor decodes every
// frame on tx and can invert one bit slot of a chosen frame on the echo path;
// expected results come from a per-byte model of the run.
module tb_echo_checker;

  localparam int unsigned B  = 6;
  localparam int unsigned TO = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic [7:0] count;
  logic       tx;
  logic       rx;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] errors;
  logic [7:0] last_rx;
`ifdef ECHO_CHECKER_INJECT_EN
  logic       inject;
`endif

  logic        line_high;
  logic        flip;
  int unsigned frame_no;
  int unsigned flip_frame;
  int          flip_slot;
  logic [9:0]  txq[$];
  logic [7:0]  model_last;

  int checks = 0;
  int errs   = 0;

  assign rx = line_high ? 1'b1 : (tx ^ flip);

  always #5 clk = ~clk;

  echo_checker #(
    .BAUDRATE(B),
    .TIMEOUT (TO)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .count  (count),
    .tx     (tx),
    .rx     (rx),
    .busy   (busy),
    .done   (done),
    .pass   (pass),
    .errors (errors),
    .last_rx(last_rx)
`ifdef ECHO_CHECKER_INJECT_EN
    ,
    .inject (inject)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line monitor: frames are timed on negedges so flip changes never meet a
  // sampling clock edge of the DUT.
  initial begin : tx_mon
    logic [9:0] bits;
    bit         aborted;
    flip     = 1'b0;
    frame_no = 0;
    forever begin
      @(negedge tx);
      aborted = 1'b0;
      bits    = '0;
      @(negedge clk);
      for (int s = 0; s < 10; s++) begin
        if (!aborted) begin
          flip = (frame_no == flip_frame) && (s == flip_slot);
          for (int c = 0; c < int'(B); c++) begin
            if (!aborted) begin
              if (c == int'(B / 2)) bits[s] = tx;
              @(negedge clk);
              if (!rstn) aborted = 1'b1;
            end
          end
        end
      end
      flip = 1'b0;
      if (!aborted) begin
        txq.push_back(bits);
        frame_no++;
      end
    end
  end

  // fframe: run-relative frame to corrupt (-1 none); fslot: 1..8 data bit
  // (fslot-1), 9 stop bit.
  task automatic run(input logic [7:0] cnt, input bit high, input int fframe,
                     input int fslot, input bit inj, input bit midstart,
                     input string tag);
    int unsigned nb;
    int unsigned exp_e;
    int unsigned budget;
    int unsigned cyc;
    bit          got;
    logic [7:0]  exp_last;
    logic [7:0]  sent;
    logic [7:0]  recv;
    logic [7:0]  mask;
    logic [9:0]  exp_tx[$];

    nb       = (cnt == 8'd0) ? 256 : int'(cnt);
    exp_e    = 0;
    exp_last = model_last;
    mask     = (fslot >= 1 && fslot <= 8) ? 8'(1 << (fslot - 1)) : 8'h00;
    for (int k = 0; k < int'(nb); k++) begin
      sent = 8'(k) ^ ((inj && k == 0) ? 8'h01 : 8'h00);
      exp_tx.push_back({1'b1, sent, 1'b0});
      if (high) begin
        exp_e++;
      end else begin
        recv     = (k == fframe) ? (sent ^ mask) : sent;
        exp_last = recv;
        if (recv != 8'(k) || (k == fframe && fslot == 9)) exp_e++;
      end
    end
    if (exp_e > 255) exp_e = 255;

    line_high  = high;
    txq.delete();
    flip_slot  = fslot;
    flip_frame = (fframe >= 0) ? frame_no + int'(fframe) : 32'hFFFF_FFFF;

    count = cnt;
    start = 1'b1;
`ifdef ECHO_CHECKER_INJECT_EN
    inject = inj;
`endif
    @(negedge clk);
    start = 1'b0;
`ifdef ECHO_CHECKER_INJECT_EN
    inject = 1'b0;
`endif
    chk({tag, "_busy_on"}, busy, 1);
    chk({tag, "_tx_start"}, tx, 0);

    budget = nb * (10 * B + TO * B + 10) + 50;
    got    = 1'b0;
    for (cyc = 0; cyc < budget; cyc++) begin
      if (midstart && cyc == 300) begin
        count = 8'd3;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (midstart && cyc == 301) chk({tag, "_busy_mid"}, busy, 1);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_errors"}, errors, 16'(exp_e));
    chk({tag, "_pass"}, pass, (exp_e == 0));
    chk({tag, "_last_rx"}, last_rx, exp_last);
    chk({tag, "_busy_off"}, busy, 0);
    if (!high)
      chk({tag, "_span"}, ((cyc + 1) >= nb * 10 * B) && ((cyc + 1) <= nb * (10 * B + B / 2 + 6)), 1);

    // A start coinciding with done must be ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_start_at_done"}, busy, 0);
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_tx"}, tx, 1);

    chk({tag, "_nframes"}, 16'(txq.size()), 16'(exp_tx.size()));
    for (int i = 0; i < txq.size() && i < exp_tx.size(); i++)
      chk({tag, "_frame"}, txq[i], exp_tx[i]);
    model_last = exp_last;
  endtask

  initial begin : main
    int n;
    rstn       = 1'b0;
    start      = 1'b0;
    count      = 8'd0;
    line_high  = 1'b1;
    flip_frame = 32'hFFFF_FFFF;
    flip_slot  = -1;
    model_last = 8'h00;
`ifdef ECHO_CHECKER_INJECT_EN
    inject = 1'b0;
`endif
    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_errors", errors, 0);
    chk("rst_last_rx", last_rx, 0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    run(8'd4, 1'b0, -1, -1, 1'b0, 1'b0, "loop4");
    run(8'd2, 1'b1, -1, -1, 1'b0, 1'b0, "tmo2");
    run(8'd3, 1'b0, 1, 4, 1'b0, 1'b0, "flip3");

    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(1, 8));
      if ($urandom_range(0, 3) == 0)
        run(8'(n), 1'b0, -1, -1, 1'b0, 1'b0, "rnd_clean");
      else
        run(8'(n), 1'b0, int'($urandom_range(0, n - 1)), int'($urandom_range(1, 9)),
            1'b0, 1'b0, "rnd_flip");
    end

    run(8'd0, 1'b0, -1, -1, 1'b0, 1'b1, "loop256");
    run(8'd0, 1'b1, -1, -1, 1'b0, 1'b0, "sat256");

    // Reset in the middle of data bit 4 of byte 0.
    line_high = 1'b0;
    flip_frame = 32'hFFFF_FFFF;
    count = 8'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5 * B + B / 2 - 1) @(negedge clk);
    chk("rst_mid_bit4", tx, 0);
    chk("rst_mid_busy", busy, 1);
    #2 rstn = 1'b0;
    #1;
    chk("rst_async_tx", tx, 1);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_errors", errors, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    model_last = 8'h00;
    repeat (3) @(negedge clk);
    run(8'd1, 1'b0, -1, -1, 1'b0, 1'b0, "post_rst");

`ifdef ECHO_CHECKER_INJECT_EN
    run(8'd2, 1'b0, -1, -1, 1'b1, 1'b0, "inject");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule

// File: doc/echo_checker.md
ECHO_CHECKER -- requirements
Module: echo_checker

Interface
REQ-001 Parameter BAUDRATE, default `B115200 (104 clocks per bit at 12 MHz, from baudgen.vh), bit period in clk cycles.
REQ-002 Parameter TIMEOUT, default 30, bit periods to wait for an echoed byte.
REQ-003 clk  in  1  system clock; all flops rising-edge.
REQ-004 rstn  in  1  asynchronous active-low reset.
REQ-005 start  in  1  one-cycle request to begin a test run.
REQ-006 count  in  8  bytes per run; 0 means 256.
REQ-007 tx  out  1  serial output to the device under test (DUT); idle high.
REQ-008 rx  in  1  serial input from the DUT; asynchronous.
REQ-009 busy  out  1  high from the accepted start until the done pulse.
REQ-010 done  out  1  one-cycle pulse at the end of a run.
REQ-011 pass  out  1  result of the last run; 1 means zero errors.
REQ-012 errors  out  8  error count of the current or last run; saturates at 255.
REQ-013 last_rx  out  8  last byte received in WAIT.

Function
REQ-014 Frame format:
- One low start bit, 8 data bits LSB first, one high stop bit.
- Each bit held exactly BAUDRATE cycles.
REQ-015 Pattern: byte k (k = 0..N-1) equals k[7:0].
REQ-016 FSM states: IDLE, SEND, WAIT, CHECK, DONE.
REQ-017 IDLE -> SEND on start; tx goes low on the cycle after start is sampled; count is latched at that point.
REQ-018 SEND -> WAIT after the last stop-bit cycle; the timeout counter clears on entry.
REQ-019 WAIT -> CHECK on a received byte; WAIT -> next on TIMEOUT*BAUDRATE cycles with no byte.
REQ-020 On timeout, errors increments and last_rx is unchanged.
REQ-021 CHECK lasts one cycle: errors increments if the byte differs from byte k or the stop bit sampled low; then -> next.
REQ-022 Next step: -> SEND for byte k+1 if k+1 < N, else -> DONE.
REQ-023 DONE lasts one cycle:
- done=1, busy drops, pass=(errors==0).
- -> IDLE.
REQ-024 Receiver:
- Two-flop synchronizer on rx.
- Falling-edge detect starts a frame; first sample at BAUDRATE/2 cycles after the edge, then every BAUDRATE cycles.
- A start bit sampled high aborts the frame silently.
REQ-025 Receiver runs in all states; bytes completing outside WAIT are discarded and not counted.
REQ-026 start is ignored while busy=1.
REQ-027 A start coinciding with done is ignored.
REQ-028 errors clears on each accepted start; pass holds its value until the next DONE.
REQ-029 errors saturates at 255 and does not wrap.

Reset
REQ-030 rstn low asynchronously forces tx=1, busy=0, done=0, pass=0, errors=0, last_rx=0, FSM=IDLE, and clears all counters.
REQ-031 Reset mid-frame abandons the frame; tx is high from the reset assertion onward.
REQ-032 After release, the synchronizer must see rx high before any falling edge is recognised.

Configuration
REQ-033 Macro ECHO_CHECKER_INJECT_EN defined:
- Adds input inject (1 bit).
- If inject=1 on the cycle a byte is loaded into SEND, bit 0 of that byte is inverted on tx.
- Expected value for CHECK stays k[7:0].
REQ-034 Macro ECHO_CHECKER_INJECT_EN undefined: no inject port, no inversion logic.

Structure
REQ-035 Shared package echo_checker_pkg holds:
- FSM state encoding.
- DATA_BITS=8.
- Frame length constant of 10 bits.
REQ-036 The receiver is a separate sub-module, echo_checker_rx. Outputs: one-cycle byte_valid, data[7:0], frame_err.
REQ-037 Transmit serializer, timeout and FSM live in echo_checker.

Verification
REQ-038 Loopback rx=tx, count=4, start pulse:
- Bytes 00,01,02,03 on tx.
- done about 4*(10+0.5)*104 cycles later.
- pass=1, errors=0, last_rx=03.
REQ-039 rx tied high, count=2: two timeouts of 30*104 cycles each; done with errors=2, pass=0.
REQ-040 Bench echo model flips bit 3 of byte 1, count=3: received 00,09,02; errors=1, pass=0.
REQ-041 Loopback, count=0:
- 256 bytes; last byte FF.
- errors=0, pass=1, last_rx=FF.
- A start pulse issued mid-run has no effect.
REQ-042 rstn pulsed low during data bit 4 of byte 0:
- tx=1 and busy=0 immediately.
- A subsequent start with count=1 passes in loopback.
REQ-043 With ECHO_CHECKER_INJECT_EN, loopback, count=2, inject=1 on byte 0: tx sends 01,01; errors=1, pass=0.
